sfp_link_supervisor: RTL and testbench

Top-level bring-up and recovery sequencer for the SFP port. Drives the reset input of the PHY reset controller and the SFP TX_DISABLE pin. Walks the link through PHY reset, transceiver ready, PCS sync and link-up, and re-runs bring-up on a filtered loss of link. Bounds failed bring-ups with a retry budget and a latched fault.

---
 rtl/sfp_link_pkg.sv | 13 +
 rtl/sync_2ff.sv | 14 +
 rtl/sfp_link_supervisor.sv | 91 +++++++++
 tb/tb_sfp_link_supervisor.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/sfp_link_pkg.sv
// sfp_link_pkg: shared widths and FSM encoding for the SFP link supervisor
package sfp_link_pkg;
  localparam int STATE_W = 3;
  localparam int RETRY_W = 4;
  typedef enum logic [STATE_W-1:0] {
    DISABLED   = 3'd0,
    RESET      = 3'd1,
    WAIT_READY = 3'd2,
    WAIT_SYNC  = 3'd3,
    LINK_UP    = 3'd4,
    FAULT      = 3'd5
  } state_e;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous pin
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or posedge reset)
    if (reset) {q, meta} <= {2{RST_VAL}};
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/sfp_link_supervisor.sv
// sfp_link_supervisor: SFP bring-up, loss-of-link recovery and retry-bounded fault sequencer
module sfp_link_supervisor
  import sfp_link_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES  = 16,
  parameter int unsigned LOCK_TIMEOUT = 125000,
  parameter int unsigned LOS_FILTER   = 16,
  parameter int unsigned MAX_RETRIES  = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sfp_mod_abs,
  input  logic               sfp_los,
  input  logic               tx_ready,
  input  logic               rx_ready,
  input  logic               rx_is_lockedtodata,
  input  logic               pcs_sync,
  input  logic               manual_restart,
  output logic               phy_reset,
  output logic               sfp_tx_disable,
  output logic               link_up,
  output logic               fault,
  output logic [RETRY_W-1:0] retry_count,
  output logic [STATE_W-1:0] state
);
  localparam logic [RETRY_W-1:0] MAX_R = RETRY_W'(MAX_RETRIES);
  logic mod_abs_s, los_s, fail, bad;
  state_e st, st_n;
  logic [31:0] tmr, tmr_n, los_cnt, los_cnt_n;
  logic [RETRY_W-1:0] retry_n;
  sync_2ff #(.RST_VAL(1'b1)) u_mod_abs (.clk(clk), .reset(reset), .d(sfp_mod_abs), .q(mod_abs_s));
  sync_2ff #(.RST_VAL(1'b1)) u_los (.clk(clk), .reset(reset), .d(sfp_los), .q(los_s));
  assign state = st;
  always_comb begin
    st_n = st;
    retry_n = retry_count;
    fail = 1'b0;
    los_cnt_n = '0;
    bad = los_s | ~rx_is_lockedtodata | ~pcs_sync | ~rx_ready;
    case (st)
      DISABLED:   st_n = RESET;
      RESET:      st_n = (tmr == '0) ? WAIT_READY : RESET;
      WAIT_READY: if (tx_ready & rx_ready) st_n = WAIT_SYNC; else fail = (tmr == '0);
      WAIT_SYNC:  if (pcs_sync & rx_ready) st_n = LINK_UP; else fail = ~rx_ready | (tmr == '0);
      LINK_UP: begin
        los_cnt_n = bad ? los_cnt + 1 : '0;
        st_n = (los_cnt_n == 32'(LOS_FILTER)) ? RESET : LINK_UP;
      end
      FAULT:      st_n = FAULT;
      default:    st_n = DISABLED;
    endcase
    if (fail) begin
      st_n = (retry_count == MAX_R) ? FAULT : RESET;
      retry_n = (retry_count == MAX_R) ? retry_count : retry_count + 1'b1;
    end
    if (st_n == LINK_UP && st != LINK_UP) retry_n = '0;
    if (manual_restart) begin
      st_n = RESET;
      retry_n = '0;
    end
    if (mod_abs_s) begin
      st_n = DISABLED;
      retry_n = '0;
    end
    // every entry (including a restart while already in RESET) reloads the timer
    tmr_n = (st_n != st || manual_restart) ?
            ((st_n == RESET) ? 32'(HOLD_CYCLES - 1) :
             (st_n == WAIT_READY || st_n == WAIT_SYNC) ? 32'(LOCK_TIMEOUT - 1) : '0) :
            ((tmr != '0) ? tmr - 1 : '0);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st <= DISABLED;
      tmr <= '0;
      los_cnt <= '0;
      retry_count <= '0;
      phy_reset <= 1'b1;
      sfp_tx_disable <= 1'b1;
      link_up <= 1'b0;
      fault <= 1'b0;
    end else begin
      st <= st_n;
      tmr <= tmr_n;
      los_cnt <= (st_n == LINK_UP) ? los_cnt_n : '0;
      retry_count <= retry_n;
      phy_reset <= (st_n == DISABLED) | (st_n == RESET) | (st_n == FAULT);
      sfp_tx_disable <= (st_n == DISABLED) | (st_n == FAULT);
      link_up <= (st_n == LINK_UP);
      fault <= (st_n == FAULT);
    end
endmodule

// File: tb/tb_sfp_link_supervisor.sv
// tb_sfp_link_supervisor: directed scenario checks for sfp_link_supervisor
module tb_sfp_link_supervisor;
  logic clk = 1'b0, reset = 1'b1;
  logic sfp_mod_abs = 1'b0, sfp_los = 1'b0, tx_ready = 1'b0, rx_ready = 1'b0;
  logic rx_is_lockedtodata = 1'b1, pcs_sync = 1'b0, manual_restart = 1'b0;
  logic phy_reset, sfp_tx_disable, link_up, fault;
  logic [3:0] retry_count;
  logic [2:0] state;
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  sfp_link_supervisor #(.HOLD_CYCLES(4), .LOCK_TIMEOUT(20), .LOS_FILTER(3), .MAX_RETRIES(2)) dut (
    .clk(clk), .reset(reset), .sfp_mod_abs(sfp_mod_abs), .sfp_los(sfp_los),
    .tx_ready(tx_ready), .rx_ready(rx_ready), .rx_is_lockedtodata(rx_is_lockedtodata),
    .pcs_sync(pcs_sync), .manual_restart(manual_restart), .phy_reset(phy_reset),
    .sfp_tx_disable(sfp_tx_disable), .link_up(link_up), .fault(fault),
    .retry_count(retry_count), .state(state));

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input logic [2:0] s, output int cyc);
    cyc = 0;
    while (state !== s && cyc < 200) begin cyc++; tick(1); end
    if (state !== s) cyc = -1;
  endtask

  task automatic count_in(input logic [2:0] s, output int n);
    n = 0;
    while (state === s && n < 200) begin n++; tick(1); end
  endtask

  task automatic test_reset;
    tick(1);
    n_tests++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state); end
    n_tests++; if ({phy_reset, sfp_tx_disable, link_up, fault} !== 4'b1100) begin n_fail++; $display("FAIL reset_outputs: got %b expected 1100", {phy_reset, sfp_tx_disable, link_up, fault}); end
    n_tests++; if (retry_count !== 4'd0) begin n_fail++; $display("FAIL reset_retry: got %0d expected 0", retry_count); end
    reset = 1'b0;
  endtask

  task automatic test_bringup;
    int c, n;
    wait_state(3'd1, c);
    n_tests++; if (c < 0) begin n_fail++; $display("FAIL bringup_enter_reset: got timeout expected state 1"); end
    count_in(3'd1, n);
    n_tests++; if (n !== 4) begin n_fail++; $display("FAIL bringup_hold: got %0d expected 4", n); end
    n_tests++; if (state !== 3'd2 || phy_reset !== 1'b0 || sfp_tx_disable !== 1'b0) begin n_fail++; $display("FAIL bringup_wait_ready: got state %0d phy_reset %b tx_dis %b expected 2 0 0", state, phy_reset, sfp_tx_disable); end
    tick(4);
    tx_ready = 1'b1; rx_ready = 1'b1;
    tick(1);
    n_tests++; if (state !== 3'd3) begin n_fail++; $display("FAIL bringup_wait_sync: got %0d expected 3", state); end
    tick(2);
    pcs_sync = 1'b1;
    tick(1);
    n_tests++; if (state !== 3'd4 || link_up !== 1'b1) begin n_fail++; $display("FAIL bringup_link: got state %0d link_up %b expected 4 1", state, link_up); end
    n_tests++; if (retry_count !== 4'd0 || phy_reset !== 1'b0) begin n_fail++; $display("FAIL bringup_retry: got retry %0d phy_reset %b expected 0 0", retry_count, phy_reset); end
  endtask

  task automatic test_los_filter;
    int n;
    pcs_sync = 1'b0;
    tick(2);
    pcs_sync = 1'b1;
    tick(1);
    n_tests++; if (link_up !== 1'b1 || state !== 3'd4) begin n_fail++; $display("FAIL los_glitch: got link_up %b state %0d expected 1 4", link_up, state); end
    rx_is_lockedtodata = 1'b0;
    tick(2);
    n_tests++; if (link_up !== 1'b1) begin n_fail++; $display("FAIL los_two_bad: got %b expected 1", link_up); end
    tick(1);
    rx_is_lockedtodata = 1'b1;
    n_tests++; if (link_up !== 1'b0 || state !== 3'd1 || phy_reset !== 1'b1) begin n_fail++; $display("FAIL los_recover: got link_up %b state %0d phy_reset %b expected 0 1 1", link_up, state, phy_reset); end
    count_in(3'd1, n);
    n_tests++; if (n !== 4) begin n_fail++; $display("FAIL los_reset_pulse: got %0d expected 4", n); end
    n_tests++; if (retry_count !== 4'd0) begin n_fail++; $display("FAIL los_retry: got %0d expected 0", retry_count); end
    tx_ready = 1'b0; rx_ready = 1'b0; pcs_sync = 1'b0;
  endtask

  task automatic test_timeouts;
    int n;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) count_in(3'd1, n);
      count_in(3'd2, n);
      n_tests++; if (n !== 20) begin n_fail++; $display("FAIL timeout_window%0d: got %0d expected 20", i, n); end
      if (i < 2) begin
        n_tests++; if (state !== 3'd1 || retry_count !== 4'(i + 1)) begin n_fail++; $display("FAIL timeout_retry%0d: got state %0d retry %0d expected 1 %0d", i, state, retry_count, i + 1); end
      end
    end
    n_tests++; if (state !== 3'd5 || fault !== 1'b1) begin n_fail++; $display("FAIL fault_entry: got state %0d fault %b expected 5 1", state, fault); end
    n_tests++; if (phy_reset !== 1'b1 || sfp_tx_disable !== 1'b1 || retry_count !== 4'd2) begin n_fail++; $display("FAIL fault_outputs: got phy_reset %b tx_dis %b retry %0d expected 1 1 2", phy_reset, sfp_tx_disable, retry_count); end
    tick(5);
    n_tests++; if (state !== 3'd5) begin n_fail++; $display("FAIL fault_sticky: got %0d expected 5", state); end
    manual_restart = 1'b1;
    tick(1);
    manual_restart = 1'b0;
    n_tests++; if (state !== 3'd1 || fault !== 1'b0 || retry_count !== 4'd0) begin n_fail++; $display("FAIL restart: got state %0d fault %b retry %0d expected 1 0 0", state, fault, retry_count); end
  endtask

  task automatic test_races;
    int n;
    count_in(3'd1, n);
    tick(19);
    n_tests++; if (state !== 3'd2) begin n_fail++; $display("FAIL race_last_cycle: got %0d expected 2", state); end
    tx_ready = 1'b1; rx_ready = 1'b1;
    tick(1);
    n_tests++; if (state !== 3'd3 || retry_count !== 4'd0) begin n_fail++; $display("FAIL race_ready_wins: got state %0d retry %0d expected 3 0", state, retry_count); end
    tick(2);
    rx_ready = 1'b0; tx_ready = 1'b0;
    tick(1);
    n_tests++; if (state !== 3'd1 || retry_count !== 4'd1) begin n_fail++; $display("FAIL race_rx_drop: got state %0d retry %0d expected 1 1", state, retry_count); end
  endtask

  task automatic test_mod_pull;
    int n;
    count_in(3'd1, n);
    tx_ready = 1'b1; rx_ready = 1'b1;
    tick(1);
    n_tests++; if (state !== 3'd3) begin n_fail++; $display("FAIL pull_setup: got %0d expected 3", state); end
    sfp_mod_abs = 1'b1;
    tick(2);
    n_tests++; if (state !== 3'd3) begin n_fail++; $display("FAIL pull_sync_delay: got %0d expected 3", state); end
    tick(1);
    n_tests++; if (state !== 3'd0 || sfp_tx_disable !== 1'b1 || phy_reset !== 1'b1 || retry_count !== 4'd0) begin n_fail++; $display("FAIL pull_disabled: got state %0d tx_dis %b phy_reset %b retry %0d expected 0 1 1 0", state, sfp_tx_disable, phy_reset, retry_count); end
  endtask

  task automatic test_async_reset;
    int c;
    sfp_mod_abs = 1'b0; pcs_sync = 1'b1;
    wait_state(3'd4, c);
    n_tests++; if (c < 0) begin n_fail++; $display("FAIL async_setup: got timeout expected state 4"); end
    reset = 1'b1;
    #1;
    n_tests++; if (state !== 3'd0 || {phy_reset, sfp_tx_disable, link_up, fault} !== 4'b1100 || retry_count !== 4'd0) begin n_fail++; $display("FAIL async_reset: got state %0d outs %b retry %0d expected 0 1100 0", state, {phy_reset, sfp_tx_disable, link_up, fault}, retry_count); end
    tick(2);
    reset = 1'b0;
  endtask

  initial begin
    test_reset;
    test_bringup;
    test_los_filter;
    test_timeouts;
    test_races;
    test_mod_pull;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
